// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
//   Shared definitions for the nibble-serial adder controller and its datapath.
//   NIBBLE_W : width of one adder slice
//   state_e  : controller state encoding (IDLE=0, RUN=1, DONE=2)
package serial_add_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_adder4.sv
// fulladd / adder4
//   Purely combinational 4-bit ripple-carry adder built from single-bit full adders.
//   fulladd : a_i, b_i, ci_i -> s_o (sum bit), co_o (carry out)
//   adder4  : a_i[3:0], b_i[3:0], ci_i -> s_o[3:0], co_o (carry out of bit 3)
module fulladd (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

module adder4
  import serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                ci_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                co_o
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    fulladd u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (s_o[i]),
      .co_o (c[i+1])
    );
  end

  assign co_o = c[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Adds two W-bit operands (W = 4*NIBBLES) through one shared adder4, one nibble
//   per clock, least-significant nibble first, with the carry registered between
//   nibbles. Start/done handshake.
//   Optional feature macro: SERIAL_ADD_SUB_EN (adds the 'sub' input; A-B when set).
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, accepted only in IDLE or DONE
//   a, b  : operands, sampled on the accept edge
//   cin   : carry into nibble 0, sampled on the accept edge
//   sub   : (SERIAL_ADD_SUB_EN only) subtract request, sampled on the accept edge
//   busy  : high while the operation runs
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result, held until the next accepted start
//   cout  : carry out of the top nibble, held like sum
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                        sub,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_EN
  logic               sub_q, sub_d;
`endif

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_co;
  logic                accept;
  logic                last;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (idx_q == IDX_W'(NIBBLES - 1));

  // Nibble select feeding the shared adder slice
  always_comb begin
    nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as A + ~B + 1: the +1 is preloaded into the carry register
    nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
`else
    nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
`endif
  end

  adder4 u_adder4 (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .ci_i (carry_q),
    .s_o  (nib_s),
    .co_o (nib_co)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    if (accept) begin
      a_d     = a;
      b_d     = b;
      sum_d   = '0;
      idx_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_d   = sub;
      carry_d = sub ? 1'b1 : cin;
`else
      carry_d = cin;
`endif
    end else if (state_q == RUN) begin
      sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_s;
      carry_d = nib_co;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) cout_d = nib_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed bench for serial_add_ctrl: a 4-nibble instance for the main
//   sequences and a 2-nibble instance for the narrow configuration.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done;
  logic [15:0] sum;
  logic        cout;

  logic        start2;
  logic [7:0]  a2, b2;
  logic        cin2;
  logic        busy2, done2;
  logic [7:0]  sum2;
  logic        cout2;

`ifdef SERIAL_ADD_SUB_EN
  logic        sub;
  logic        sub2;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.NIBBLES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub2),
`endif
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the request
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
`ifdef SERIAL_ADD_SUB_EN
    sub   = is;
`else
    if (is) $display("note: sub request without subtract support");
`endif
  endtask

  // Counts negedges until done is seen (bounded); n = -1 on timeout
  task automatic wait_done(output int n, output int bc);
    n  = -1;
    bc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is, input logic [15:0] es, input logic ec);
    int n, bc;
    issue(ia, ib, ic, is);
    wait_done(n, bc);
    chk({tag, ".latency"}, n, 5);
    chk({tag, ".busy_cycles"}, bc, 4);
    chk({tag, ".sum"}, {16'h0, sum}, {16'h0, es});
    chk({tag, ".cout"}, {31'h0, cout}, {31'h0, ec});
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'h0, done}, 32'h0);
    chk({tag, ".sum_held"}, {16'h0, sum}, {16'h0, es});
  endtask

  initial begin
    int n, bc;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;
    cin2   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub    = 1'b0;
    sub2   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset.busy", {31'h0, busy}, 32'h0);
    chk("reset.done", {31'h0, done}, 32'h0);
    chk("reset.sum",  {16'h0, sum},  32'h0);
    chk("reset.cout", {31'h0, cout}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add and latency
    run_op("t1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    // Carry rippling through every nibble
    run_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("t2b", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);

    // Start while busy is ignored; start in DONE is accepted
    issue(16'h000B, 16'h0004, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("t3.busy", {31'h0, busy}, 32'h1);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    chk("t3.remaining", n, 3);
    chk("t3.sum", {16'h0, sum}, 32'h0000_000F);
    chk("t3.cout", {31'h0, cout}, 32'h0);
    issue(16'hF000, 16'h1000, 1'b0, 1'b0);
    wait_done(n, bc);
    chk("t3.b2b_latency", n, 5);
    chk("t3.b2b_sum", {16'h0, sum}, 32'h0);
    chk("t3.b2b_cout", {31'h0, cout}, 32'h1);
    @(negedge clk);

    // Reset asserted mid-run at idx=2
    issue(16'h1111, 16'h1111, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("t4.partial", {16'h0, sum}, 32'h0000_0022);
    rst_n = 1'b0;
    #1;
    chk("t4.busy", {31'h0, busy}, 32'h0);
    chk("t4.done", {31'h0, done}, 32'h0);
    chk("t4.sum",  {16'h0, sum},  32'h0);
    chk("t4.cout", {31'h0, cout}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4.idle_busy", {31'h0, busy}, 32'h0);
    chk("t4.idle_done", {31'h0, done}, 32'h0);
    run_op("t4b", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("t5a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    run_op("t5b", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

    // Two-nibble instance
    start2 = 1'b1;
    a2     = 8'h8F;
    b2     = 8'h71;
    cin2   = 1'b0;
    n      = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2 === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("t6.latency", n, 3);
    chk("t6.sum",  {24'h0, sum2},  32'h0);
    chk("t6.cout", {31'h0, cout2}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
